// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one synchronous data memory between a CPU controller
// and a host/debug port. One access per cycle, round-robin between the two
// requesters, with an optional sticky host lock that is bounded so the CPU
// can never be starved for more than LOCK_MAX consecutive host grants.
module dmem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  // CPU controller port
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  // host/debug port
  input  logic              host_req,
  input  logic              host_wr,
  input  logic              host_lock,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  // memory port
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // State names the owner of the most recent grant.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CPU       = 2'd1,
    HOST      = 2'd2,
    HOST_LOCK = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  lock_cnt;
  logic [CNT_W-1:0]  lock_cnt_next;
  logic              grant_cpu;
  logic              grant_host;
  logic              cpu_rd_pend;
  logic              host_rd_pend;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] host_rdata_q;

  // Owner state and lock counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lock_cnt <= '0;
    end else begin
      state    <= state_next;
      lock_cnt <= lock_cnt_next;
    end
  end

  // Grant decision and next owner; grants are suppressed while in reset so
  // every output reads zero during reset.
  always_comb begin
    grant_cpu     = 1'b0;
    grant_host    = 1'b0;
    state_next    = IDLE;
    lock_cnt_next = '0;

    if (rst_n) begin
      if (cpu_req && host_req) begin
        case (state)
          CPU: begin
            grant_host = 1'b1;
          end
          HOST_LOCK: begin
            // A dropped host_lock behaves like plain HOST: CPU wins the tie.
            if (host_lock && (lock_cnt < CNT_MAX)) begin
              grant_host = 1'b1;
            end else begin
              grant_cpu = 1'b1;
            end
          end
          default: begin
            grant_cpu = 1'b1;
          end
        endcase
      end else if (cpu_req) begin
        grant_cpu = 1'b1;
      end else if (host_req) begin
        grant_host = 1'b1;
      end

      if (grant_cpu) begin
        state_next    = CPU;
        lock_cnt_next = '0;
      end else if (grant_host) begin
        if (host_lock) begin
          state_next = HOST_LOCK;
          // Only locked grants that actually make the CPU wait are counted.
          if (cpu_req) begin
            lock_cnt_next = lock_cnt + CNT_ONE;
          end else begin
            lock_cnt_next = lock_cnt;
          end
        end else begin
          state_next    = HOST;
          lock_cnt_next = '0;
        end
      end else begin
        state_next    = IDLE;
        lock_cnt_next = '0;
      end
    end
  end

  // Memory port mux: granted requester drives the bus, zeros otherwise.
  always_comb begin
    mem_addr  = '0;
    mem_wr    = 1'b0;
    mem_wdata = '0;
    if (grant_cpu) begin
      mem_addr  = cpu_addr;
      mem_wr    = cpu_wr;
      mem_wdata = cpu_wdata;
    end else if (grant_host) begin
      mem_addr  = host_addr;
      mem_wr    = host_wr;
      mem_wdata = host_wdata;
    end
  end

  assign cpu_gnt  = grant_cpu;
  assign host_gnt = grant_host;

  // Remember which requester has a read in flight; reset drops it so a read
  // granted just before reset never returns data afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rd_pend  <= 1'b0;
      host_rd_pend <= 1'b0;
    end else begin
      cpu_rd_pend  <= grant_cpu & ~cpu_wr;
      host_rd_pend <= grant_host & ~host_wr;
    end
  end

  // Hold the last returned read data for each requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      if (cpu_rd_pend) begin
        cpu_rdata_q <= mem_rdata;
      end
      if (host_rd_pend) begin
        host_rdata_q <= mem_rdata;
      end
    end
  end

  assign cpu_rvalid  = cpu_rd_pend;
  assign host_rvalid = host_rd_pend;
  assign cpu_rdata   = cpu_rd_pend ? mem_rdata : cpu_rdata_q;
  assign host_rdata  = host_rd_pend ? mem_rdata : host_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus a long random run of dmem_arbiter
// against a synchronous RAM and a behavioural arbitration/memory model.
module tb_dmem_arbiter;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 16;
  localparam int LOCK_MAX = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cpu_req = 1'b0, cpu_wr = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              cpu_gnt, cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              host_req = 1'b0, host_wr = 1'b0, host_lock = 1'b0;
  logic [ADDR_W-1:0] host_addr = '0;
  logic [DATA_W-1:0] host_wdata = '0;
  logic              host_gnt, host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;

  int compared = 0;
  int mismatched = 0;

  // Reference model: owner of last grant (0 none, 1 cpu, 2 host, 3 locked
  // host), count of locked host grants made while the CPU waited, memory
  // contents, and per-requester read-return bookkeeping.
  int                last_owner = 0;
  int                locked_run = 0;
  int                cpu_wait = 0;
  logic [DATA_W-1:0] ref_mem [0:255];
  logic [DATA_W-1:0] sram [0:255];
  bit                cpu_pend = 0, host_pend = 0;
  logic [DATA_W-1:0] cpu_pend_data = '0, host_pend_data = '0;
  logic [DATA_W-1:0] cpu_hold = '0, host_hold = '0;
  bit                got_c, got_h;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_wr(host_wr), .host_lock(host_lock),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous RAM: data appears one cycle after the address is sampled.
  always @(posedge clk) begin
    if (mem_wr) sram[mem_addr] <= mem_wdata;
    mem_rdata <= sram[mem_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of requests, check against the model, advance the model.
  task automatic applyStimulus(input logic cr, input logic cw, input logic [7:0] ca,
                               input logic [15:0] cd, input logic hr, input logic hw,
                               input logic hl, input logic [7:0] ha, input logic [15:0] hd);
    bit ec, eh;
    @(negedge clk);
    cpu_req = cr; cpu_wr = cw; cpu_addr = ca; cpu_wdata = cd;
    host_req = hr; host_wr = hw; host_lock = hl; host_addr = ha; host_wdata = hd;
    #1;
    ec = 0; eh = 0;
    if (cr && hr) begin
      if (last_owner == 1) eh = 1;
      else if (last_owner == 3 && hl && locked_run < LOCK_MAX) eh = 1;
      else ec = 1;
    end else if (cr) ec = 1;
    else if (hr) eh = 1;

    checkOutput("cpu_gnt", cpu_gnt, ec);
    checkOutput("host_gnt", host_gnt, eh);
    checkOutput("double_gnt", cpu_gnt & host_gnt, 0);
    checkOutput("mem_wr", mem_wr, ec ? cw : (eh ? hw : 1'b0));
    checkOutput("mem_addr", mem_addr, ec ? ca : (eh ? ha : 8'h00));
    checkOutput("mem_wdata", mem_wdata, ec ? cd : (eh ? hd : 16'h0000));
    checkOutput("cpu_rvalid", cpu_rvalid, cpu_pend);
    checkOutput("cpu_rdata", cpu_rdata, cpu_pend ? cpu_pend_data : cpu_hold);
    checkOutput("host_rvalid", host_rvalid, host_pend);
    checkOutput("host_rdata", host_rdata, host_pend ? host_pend_data : host_hold);

    if (cr && !cpu_gnt) cpu_wait++;
    else cpu_wait = 0;
    if (cr) checkOutput("cpu_wait_bound", (cpu_wait <= LOCK_MAX + 1), 1);

    if (cpu_pend) cpu_hold = cpu_pend_data;
    if (host_pend) host_hold = host_pend_data;
    cpu_pend = ec && !cw;
    host_pend = eh && !hw;
    cpu_pend_data = ref_mem[ca];
    host_pend_data = ref_mem[ha];
    if (ec && cw) ref_mem[ca] = cd;
    if (eh && hw) ref_mem[ha] = hd;

    if (ec) begin
      last_owner = 1; locked_run = 0;
    end else if (eh) begin
      if (hl) begin
        last_owner = 3;
        if (cr) locked_run++;
      end else begin
        last_owner = 2; locked_run = 0;
      end
    end else begin
      last_owner = 0; locked_run = 0;
    end
    got_c = ec; got_h = eh;
  endtask

  // Hold reset for two cycles checking every output is zero, then release
  // with requests idle.
  task automatic doReset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      checkOutput("rst_gnt", {cpu_gnt, host_gnt}, 0);
      checkOutput("rst_rvalid", {cpu_rvalid, host_rvalid}, 0);
      checkOutput("rst_mem_wr", mem_wr, 0);
      checkOutput("rst_rdata", {cpu_rdata, host_rdata}, 0);
      checkOutput("rst_mem_bus", {mem_addr, mem_wdata}, 0);
    end
    cpu_req = 0; host_req = 0; host_lock = 0; cpu_wr = 0; host_wr = 0;
    last_owner = 0; locked_run = 0; cpu_wait = 0;
    cpu_pend = 0; host_pend = 0; cpu_hold = '0; host_hold = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic              c_req, c_wr, h_req, h_wr, h_lock;
    logic [ADDR_W-1:0] c_addr, h_addr;
    logic [DATA_W-1:0] c_data, h_data;

    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = '0;
      sram[i] = '0;
    end

    $display("[TB] reset and CPU write/read");
    doReset();
    applyStimulus(1, 1, 8'h10, 16'h1234, 0, 0, 0, 8'h00, 16'h0);
    checkOutput("s1_wr_gnt", cpu_gnt, 1);
    checkOutput("s1_wr_strobe", mem_wr, 1);
    applyStimulus(1, 0, 8'h10, 16'h0000, 0, 0, 0, 8'h00, 16'h0);
    checkOutput("s1_rd_gnt", cpu_gnt, 1);
    checkOutput("s1_rd_strobe", mem_wr, 0);
    applyStimulus(0, 0, 8'h00, 16'h0000, 0, 0, 0, 8'h00, 16'h0);
    checkOutput("s1_rvalid", cpu_rvalid, 1);
    checkOutput("s1_rdata", cpu_rdata, 16'h1234);

    $display("[TB] round-robin without lock");
    doReset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 0, 8'(i), 16'h0, 1, 0, 0, 8'(8'h20 + i), 16'h0);
      checkOutput("s2_alternate", cpu_gnt, (i % 2 == 0));
    end

    $display("[TB] locked host with bounded starvation");
    doReset();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 0, 8'(i), 16'h0, 1, 0, 1, 8'(8'h40 + i), 16'h0);
      checkOutput("s3_lock_pattern", cpu_gnt, (i % (LOCK_MAX + 1) == 0));
    end

    $display("[TB] host read burst");
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 8'h00, 16'h0, (i < 4), 0, 0, 8'(i), 16'h0);
      checkOutput("s4_host_gnt", host_gnt, (i < 4));
      checkOutput("s4_host_rvalid", host_rvalid, (i > 0));
      checkOutput("s4_cpu_rvalid", cpu_rvalid, 0);
    end

    $display("[TB] reset during host read");
    applyStimulus(0, 0, 8'h00, 16'h0, 1, 0, 0, 8'h05, 16'h0);
    checkOutput("s5_host_gnt", host_gnt, 1);
    #1;
    rst_n = 1'b0;
    doReset();
    applyStimulus(0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 16'h0);
    checkOutput("s5_no_rvalid", host_rvalid, 0);

    $display("[TB] random traffic");
    c_req = 0; c_wr = 0; c_addr = '0; c_data = '0;
    h_req = 0; h_wr = 0; h_addr = '0; h_data = '0;
    for (int n = 0; n < 10000; n++) begin
      if (!c_req) begin
        c_req = ($urandom_range(0, 3) != 0);
        c_wr = $urandom_range(0, 1);
        c_addr = 8'($urandom_range(0, 15));
        c_data = 16'($urandom);
      end
      if (!h_req) begin
        h_req = ($urandom_range(0, 3) != 0);
        h_wr = $urandom_range(0, 1);
        h_addr = 8'($urandom_range(0, 15));
        h_data = 16'($urandom);
      end
      h_lock = ($urandom_range(0, 3) != 0);
      applyStimulus(c_req, c_wr, c_addr, c_data, h_req, h_wr, h_lock, h_addr, h_data);
      if (got_c) c_req = 0;
      if (got_h) h_req = 0;
    end
    applyStimulus(0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 16'h0);
    applyStimulus(0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
